// File: rtl/epu_dma_pkg.sv
// Shared types and constants for the EPU DMA engine.
// Includes the state encoding, AXI constants and the burst-sizing helper.
package epu_dma_pkg;

  localparam int BURST_MAX = 16;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0] SIZE_WORD       = 3'b010;
  localparam logic [3:0] DMA_ID          = 4'h1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_DONE
  } state_t;

  // Largest burst that stays within BURST_MAX, the words left to move and the
  // current 4 KB page of the source (and of the destination when dst_lim is set).
  function automatic logic [4:0] calc_beats(input logic [31:0] src,
                                            input logic [31:0] dst,
                                            input logic [15:0] rem,
                                            input logic        dst_lim);
    logic [10:0] src_room;
    logic [10:0] dst_room;
    logic [15:0] b;
    src_room = 11'd1024 - {1'b0, src[11:2]};
    dst_room = 11'd1024 - {1'b0, dst[11:2]};
    b = (rem < 16'(BURST_MAX)) ? rem : 16'(BURST_MAX);
    if ({5'd0, src_room} < b) b = {5'd0, src_room};
    if (dst_lim && ({5'd0, dst_room} < b)) b = {5'd0, dst_room};
    return b[4:0];
  endfunction

endpackage

// File: rtl/epu_dma_fifo.sv
// 16x32 synchronous FIFO holding one read burst until it is written out.
// Head is the oldest entry; push when full and pop when empty are ignored.
module epu_dma_fifo
  import epu_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] head,
  output logic [4:0]  count,
  output logic        empty,
  output logic        full
);

  logic [31:0] mem [BURST_MAX];
  logic [3:0]  wptr;
  logic [3:0]  rptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (count == 5'd0);
  assign full    = (count == 5'(BURST_MAX));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 4'd0;
      rptr  <= 4'd0;
      count <= 5'd0;
    end else begin
      if (do_push) wptr <= wptr + 4'd1;
      if (do_pop)  rptr <= rptr + 4'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/epu_dma.sv
// AXI4 read-then-write DMA master feeding the EPU raw-data port.
// EPU_DMA_DST_INCR_EN: destination advances per burst (INCR); otherwise fixed AWADDR.
//
// Handshakes: a transfer happens on the rising clk edge where VALID and READY
// are both high; VALID/address/data are held stable until that edge. All VALID
// and READY outputs are registered except WVALID, which follows the FIFO count.
module epu_dma
  import epu_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output state_t      dbg_state
);

`ifdef EPU_DMA_DST_INCR_EN
  localparam logic DST_INCR = 1'b1;
`else
  localparam logic DST_INCR = 1'b0;
`endif

  state_t      state;
  logic [31:0] cur_src;
  logic [31:0] cur_dst;
  logic [15:0] remaining;
  logic [4:0]  beats;
  logic [4:0]  rcnt;
  logic [3:0]  wcnt;

  logic [31:0] nxt_src;
  logic [31:0] nxt_dst;
  logic [15:0] nxt_rem;
  logic [4:0]  nxt_beats;
  logic [4:0]  start_beats;
  logic        r_hs;
  logic        w_hs;
  logic        b_hs;

  logic        fifo_push;
  logic [31:0] fifo_head;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        unused_ok;

  assign ARID      = DMA_ID;
  assign ARSIZE    = SIZE_WORD;
  assign ARBURST   = AXI_BURST_INCR;
  assign AWID      = DMA_ID;
  assign AWSIZE    = SIZE_WORD;
  assign AWBURST   = DST_INCR ? AXI_BURST_INCR : AXI_BURST_FIXED;
  assign WSTRB     = 4'hF;
  assign WVALID    = (state == S_WDATA) && !fifo_empty;
  assign WLAST     = (state == S_WDATA) && (wcnt == AWLEN);
  assign WDATA     = fifo_head;
  assign dbg_state = state;
  assign unused_ok = ^{RID, BID, fifo_count};

  assign r_hs = RVALID && RREADY;
  assign w_hs = WVALID && WREADY;
  assign b_hs = BVALID && BREADY;
  // Beats beyond ARLEN (late RLAST) are dropped rather than overfilling the FIFO.
  assign fifo_push = r_hs && (rcnt != beats) && !fifo_full;

  always_comb begin
    nxt_src     = cur_src + {25'd0, beats, 2'b00};
    nxt_dst     = DST_INCR ? (cur_dst + {25'd0, beats, 2'b00}) : cur_dst;
    nxt_rem     = remaining - {11'd0, beats};
    nxt_beats   = calc_beats(nxt_src, nxt_dst, nxt_rem, DST_INCR);
    start_beats = calc_beats({src_addr[31:2], 2'b00}, {dst_addr[31:2], 2'b00},
                             len_words, DST_INCR);
  end

  epu_dma_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (w_hs),
    .din   (RDATA),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_src   <= 32'd0;
      cur_dst   <= 32'd0;
      remaining <= 16'd0;
      beats     <= 5'd0;
      rcnt      <= 5'd0;
      wcnt      <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ARADDR    <= 32'd0;
      ARLEN     <= 4'd0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= 32'd0;
      AWLEN     <= 4'd0;
      AWVALID   <= 1'b0;
      BREADY    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_src   <= {src_addr[31:2], 2'b00};
            cur_dst   <= {dst_addr[31:2], 2'b00};
            remaining <= len_words;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (len_words == 16'd0) begin
              state <= S_DONE;
            end else begin
              state   <= S_RADDR;
              ARVALID <= 1'b1;
              ARADDR  <= {src_addr[31:2], 2'b00};
              ARLEN   <= 4'(start_beats - 5'd1);
              beats   <= start_beats;
              rcnt    <= 5'd0;
            end
          end
        end
        S_RADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (r_hs) begin
            if (rcnt != beats) rcnt <= rcnt + 5'd1;
            if (RRESP != AXI_RESP_OKAY) err <= 1'b1;
            if (RLAST) begin
              if (rcnt != beats - 5'd1) err <= 1'b1;
              RREADY  <= 1'b0;
              AWVALID <= 1'b1;
              AWADDR  <= cur_dst;
              // An early RLAST shortens the write burst to what actually arrived.
              AWLEN   <= (rcnt < beats - 5'd1) ? rcnt[3:0] : ARLEN;
              state   <= S_WADDR;
            end
          end
        end
        S_WADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            wcnt    <= 4'd0;
            state   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            wcnt <= wcnt + 4'd1;
            if (WLAST) begin
              BREADY <= 1'b1;
              state  <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (b_hs) begin
            BREADY    <= 1'b0;
            if (BRESP != AXI_RESP_OKAY) err <= 1'b1;
            cur_src   <= nxt_src;
            cur_dst   <= nxt_dst;
            remaining <= nxt_rem;
            if (nxt_rem == 16'd0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              ARVALID <= 1'b1;
              ARADDR  <= nxt_src;
              ARLEN   <= 4'(nxt_beats - 5'd1);
              beats   <= nxt_beats;
              rcnt    <= 5'd0;
              state   <= S_RADDR;
            end
          end
        end
        S_DONE: begin
          // Entered with done already set after a B response; a zero-length
          // start arrives here with done low and pulses it one cycle later.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epu_dma.sv
// Directed bench for epu_dma with a reactive AXI memory/slave model.
// Written for the default build (fixed destination address).
module tb_epu_dma;
  import epu_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len_words;
  logic        busy, done, err;
  logic [3:0]  ARID, ARLEN, RID, AWID, AWLEN, WSTRB, BID;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, RRESP, AWBURST, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  state_t      dbg_state;

  epu_dma dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .err(err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [35:0] arlog[$];
  logic [35:0] awlog[$];
  int          done_cnt = 0;
  int          bidx = 0;
  int          slverr_idx = -1;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // ---------------- AXI slave model ----------------
  logic [35:0] rq[$];
  logic [3:0]  awq[$];
  logic [31:0] r_addr, w_data, prev_wdata;
  logic [3:0]  r_len;
  int          r_left, w_beat, b_cnt;
  bit          r_active, r_hs, w_hs, w_last, b_hs, prev_stall;

  initial begin
    ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; RLAST = 0; RDATA = 0;
    RRESP = 0; RID = 4'h1; BID = 4'h1; BVALID = 0; BRESP = 0;
    r_active = 0; r_hs = 0; w_hs = 0; b_hs = 0; prev_stall = 0;
    w_beat = 0; b_cnt = 0; r_left = 0; r_addr = 0; r_len = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rst) begin
        rq.delete(); awq.delete();
        r_active = 0; b_cnt = 0; w_beat = 0;
        r_hs = 0; w_hs = 0; b_hs = 0; prev_stall = 0;
        RVALID = 0; RLAST = 0; BVALID = 0; ARREADY = 0; AWREADY = 0; WREADY = 0;
      end else begin
        if (r_hs) begin
          r_addr += 32'd4;
          r_left--;
          if (r_left == 0) r_active = 0;
        end
        if (w_hs) begin
          chk("sb_beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("wdata", w_data, exp_q.pop_front());
          if (awq.size() > 0) chk("wlast", w_last, w_beat == int'(awq[0]));
          if (w_last) begin
            w_beat = 0;
            if (awq.size() > 0) void'(awq.pop_front());
            b_cnt++;
          end else begin
            w_beat++;
          end
        end
        if (b_hs) begin
          b_cnt--;
          bidx++;
        end
        if (!r_active && rq.size() > 0) begin
          {r_addr, r_len} = rq.pop_front();
          r_left = int'(r_len) + 1;
          r_active = 1;
        end
        ARREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        AWREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        WREADY  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        RVALID  = r_active;
        RDATA   = mem_word(r_addr);
        RLAST   = r_active && (r_left == 1);
        RRESP   = 2'b00;
        BVALID  = (b_cnt > 0);
        BRESP   = (bidx == slverr_idx) ? 2'b10 : 2'b00;
        if (prev_stall) begin
          chk("stall_wvalid", WVALID, 1);
          chk("stall_wdata", WDATA, prev_wdata);
        end
        if (ARVALID && ARREADY) begin
          arlog.push_back({ARADDR, ARLEN});
          rq.push_back({ARADDR, ARLEN});
        end
        if (AWVALID && AWREADY) begin
          awlog.push_back({AWADDR, AWLEN});
          awq.push_back(AWLEN);
        end
        r_hs = RVALID && RREADY;
        w_hs = WVALID && WREADY;
        w_data = WDATA;
        w_last = WLAST;
        b_hs = BVALID && BREADY;
        prev_stall = WVALID && !WREADY;
        prev_wdata = WDATA;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_word(s + 32'(4 * i)));
    arlog.delete(); awlog.delete();
    bidx = 0; done_cnt = 0;
    start = 1'b1; src_addr = s; dst_addr = d; len_words = n;
    @(negedge clk);
    start = 1'b0;
    chk("busy_t1", busy, 1);
    if (n != 16'd0) chk("arvalid_t1", ARVALID, 1);
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", got, 1);
    if (got) chk("busy_low_at_done", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_ar(input int i, input logic [31:0] a, input logic [3:0] l);
    chk($sformatf("ar%0d_addr", i), arlog[i][35:4], a);
    chk($sformatf("ar%0d_len", i), arlog[i][3:0], l);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; src_addr = 0; dst_addr = 0; len_words = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_state", dbg_state, S_IDLE);
    chk("const_arid", ARID, 4'h1);
    chk("const_arsize", ARSIZE, 3'b010);
    chk("const_arburst", ARBURST, 2'b01);
    chk("const_awburst", AWBURST, 2'b00);
    chk("const_wstrb", WSTRB, 4'hF);

    // 40 words to the EPU raw port, zero-wait memory
    start_xfer(32'h0000_2000, 32'h0010_0000, 16'd40);
    wait_done(2000);
    chk("t1_nbursts", arlog.size(), 3);
    chk_ar(0, 32'h2000, 4'd15);
    chk_ar(1, 32'h2040, 4'd15);
    chk_ar(2, 32'h2080, 4'd7);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_awaddr%0d", i), awlog[i][35:4], 32'h0010_0000);
    chk("t1_awlen2", awlog[2][3:0], 4'd7);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", err, 0);

    // 4 KB boundary split
    start_xfer(32'h0000_0FF8, 32'h0010_0000, 16'd6);
    wait_done(1000);
    chk("t2_nbursts", arlog.size(), 2);
    chk_ar(0, 32'h0FF8, 4'd1);
    chk_ar(1, 32'h1000, 4'd3);
    chk("t2_drained", exp_q.size(), 0);

    // random READY stalls
    rand_rdy = 1'b1;
    start_xfer(32'h0000_3004, 32'h0010_0000, 16'd20);
    wait_done(3000);
    rand_rdy = 1'b0;
    chk("t3_nbursts", arlog.size(), 2);
    chk_ar(0, 32'h3004, 4'd15);
    chk_ar(1, 32'h3044, 4'd3);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_done_cnt", done_cnt, 1);

    // zero length: busy one cycle, done two cycles after start
    start_xfer(32'h0000_4000, 32'h0010_0000, 16'd0);
    chk("t4_done_t1", done, 0);
    chk("t4_arvalid_t1", ARVALID, 0);
    @(negedge clk);
    chk("t4_done_t2", done, 1);
    chk("t4_busy_t2", busy, 0);
    @(negedge clk);
    chk("t4_done_t3", done, 0);
    repeat (2) @(negedge clk);
    chk("t4_no_ar", arlog.size(), 0);
    chk("t4_done_cnt", done_cnt, 1);

    // SLVERR on second B response; transfer still completes
    slverr_idx = 1;
    start_xfer(32'h0000_2000, 32'h0010_0000, 16'd40);
    wait_done(2000);
    slverr_idx = -1;
    chk("t5_err", err, 1);
    chk("t5_nbursts", arlog.size(), 3);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_done_cnt", done_cnt, 1);
    start_xfer(32'h0000_2400, 32'h0010_0000, 16'd4);
    chk("t5_err_cleared", err, 0);
    wait_done(500);
    chk("t5_err_after", err, 0);

    // reset during WDATA
    start_xfer(32'h0000_5000, 32'h0010_0000, 16'd16);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (WVALID) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_reached_wdata", seen, 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t6_arvalid", ARVALID, 0);
    chk("t6_awvalid", AWVALID, 0);
    chk("t6_wvalid", WVALID, 0);
    chk("t6_rready", RREADY, 0);
    chk("t6_bready", BREADY, 0);
    chk("t6_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_cnt, 0);
    start_xfer(32'h0000_6000, 32'h0010_0000, 16'd4);
    wait_done(500);
    chk("t6_nbursts", arlog.size(), 1);
    chk_ar(0, 32'h6000, 4'd3);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
